// File: rtl/exe_op_issuer_if.sv
// Bus bundle between the command sequencer and its surroundings: the command
// load port, the run control, the exe-unit operand/result path and the tagged
// result stream. The slave modport is the sequencer's view; master is the
// control/stimulus side that also plays the exe unit.
interface exe_op_issuer_if #(
  parameter int m     = 4,
  parameter int n     = 2,
  parameter int DEPTH = 8
);
  localparam int IW = $clog2(DEPTH);

  logic          i_load_valid;
  logic [n-1:0]  i_load_oper;
  logic [m-1:0]  i_load_argA;
  logic [m-1:0]  i_load_argB;
  logic          o_load_ready;
  logic          i_start;
  logic          o_busy;
  logic          o_done;
  logic [n-1:0]  o_oper;
  logic [m-1:0]  o_argA;
  logic [m-1:0]  o_argB;
  logic          o_issue_valid;
  logic [m-1:0]  i_result;
  logic [1:0]    i_status;
  logic          o_res_valid;
  logic [IW-1:0] o_res_idx;
  logic [m-1:0]  o_res_data;
  logic [1:0]    o_res_status;
  logic [1:0]    o_status_acc;

  modport slave (
    input  i_load_valid, i_load_oper, i_load_argA, i_load_argB, i_start,
           i_result, i_status,
    output o_load_ready, o_busy, o_done, o_oper, o_argA, o_argB, o_issue_valid,
           o_res_valid, o_res_idx, o_res_data, o_res_status, o_status_acc
  );

  modport master (
    output i_load_valid, i_load_oper, i_load_argA, i_load_argB, i_start,
           i_result, i_status,
    input  o_load_ready, o_busy, o_done, o_oper, o_argA, o_argB, o_issue_valid,
           o_res_valid, o_res_idx, o_res_data, o_res_status, o_status_acc
  );
endinterface

// File: rtl/exe_op_issuer.sv
// Command sequencer: buffers up to DEPTH commands, issues them back to back
// to an exe unit on start, captures each result LAT edges after its command
// appeared, and streams the results out tagged with their buffer index.
module exe_op_issuer #(
  parameter int m     = 4,
  parameter int n     = 2,
  parameter int DEPTH = 8,
  parameter int LAT   = 1
) (
  input  logic            i_clk,
  input  logic            i_rsn,
  exe_op_issuer_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] W_FULL = (IW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        r_state;
  state_t        w_next;

  logic [n-1:0]  r_buf_oper [DEPTH];
  logic [m-1:0]  r_buf_argA [DEPTH];
  logic [m-1:0]  r_buf_argB [DEPTH];

  logic [IW:0]   r_count;
  logic [IW-1:0] r_wr_ptr;
  logic [IW-1:0] r_rd_ptr;

  logic [n-1:0]  r_oper;
  logic [m-1:0]  r_argA;
  logic [m-1:0]  r_argB;
  logic          r_issue_valid;

  logic [LAT-1:0] r_pipe_v;
  logic [IW-1:0]  r_pipe_idx [LAT];

  logic          r_res_valid;
  logic [IW-1:0] r_res_idx;
  logic [m-1:0]  r_res_data;
  logic [1:0]    r_res_status;
  logic [1:0]    r_status_acc;

  logic          w_load_ready;
  logic          w_load_fire;
  logic [IW:0]   w_count_after;
  logic          w_last_issue;
  logic          w_pipe_early;

  assign w_load_ready  = (r_state == IDLE) && (r_count < W_FULL);
  assign w_load_fire   = w_load_ready && bus.i_load_valid;
  assign w_count_after = r_count + {{IW{1'b0}}, w_load_fire};
  assign w_last_issue  = (r_state == RUN) && ({1'b0, r_rd_ptr} == (r_count - (IW+1)'(1)));

  // Any live entry short of the last stage means results are still in flight
  always_comb begin
    w_pipe_early = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      w_pipe_early = w_pipe_early | r_pipe_v[i];
    end
  end

  // Next-state: an empty start skips straight to DONE; DRAIN ends on the edge that captures the last result
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.i_start) w_next = (w_count_after == '0) ? DONE : RUN;
      RUN:     if (w_last_issue) w_next = DRAIN;
      DRAIN:   if (!w_pipe_early) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rsn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Command storage; contents need no reset since count gates every read
  always_ff @(posedge i_clk) begin
    if (w_load_fire) begin
      r_buf_oper[r_wr_ptr] <= bus.i_load_oper;
      r_buf_argA[r_wr_ptr] <= bus.i_load_argA;
      r_buf_argB[r_wr_ptr] <= bus.i_load_argB;
    end
  end

  // Buffer bookkeeping: loads only in IDLE, one read per RUN cycle, everything emptied in DONE
  always_ff @(posedge i_clk) begin
    if (i_rsn) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load_fire) begin
            r_wr_ptr <= r_wr_ptr + IW'(1);
            r_count  <= w_count_after;
          end
          if (bus.i_start) r_rd_ptr <= '0;
        end
        RUN:  r_rd_ptr <= r_rd_ptr + IW'(1);
        DONE: begin
          r_count  <= '0;
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
        end
        default: ;
      endcase
    end
  end

  // Operand registers toward the exe unit; they keep the last command once issuing stops
  always_ff @(posedge i_clk) begin
    if (i_rsn) begin
      r_oper        <= '0;
      r_argA        <= '0;
      r_argB        <= '0;
      r_issue_valid <= 1'b0;
    end else if (r_state == RUN) begin
      r_oper        <= r_buf_oper[r_rd_ptr];
      r_argA        <= r_buf_argA[r_rd_ptr];
      r_argB        <= r_buf_argB[r_rd_ptr];
      r_issue_valid <= 1'b1;
    end else begin
      r_issue_valid <= 1'b0;
    end
  end

  // Latency pipe: stage 0 lines up with the issued command, the last stage marks its capture edge
  always_ff @(posedge i_clk) begin
    if (i_rsn) begin
      r_pipe_v <= '0;
      for (int i = 0; i < LAT; i++) r_pipe_idx[i] <= '0;
    end else begin
      r_pipe_v[0]   <= (r_state == RUN);
      r_pipe_idx[0] <= r_rd_ptr;
      for (int i = 1; i < LAT; i++) begin
        r_pipe_v[i]   <= r_pipe_v[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
    end
  end

  // Result capture and the sticky status accumulator, which restarts when a run begins
  always_ff @(posedge i_clk) begin
    if (i_rsn) begin
      r_res_valid  <= 1'b0;
      r_res_idx    <= '0;
      r_res_data   <= '0;
      r_res_status <= '0;
      r_status_acc <= '0;
    end else begin
      r_res_valid <= r_pipe_v[LAT-1];
      if (r_pipe_v[LAT-1]) begin
        r_res_idx    <= r_pipe_idx[LAT-1];
        r_res_data   <= bus.i_result;
        r_res_status <= bus.i_status;
        r_status_acc <= r_status_acc | bus.i_status;
      end else if ((r_state == IDLE) && bus.i_start) begin
        r_status_acc <= '0;
      end
    end
  end

  assign bus.o_load_ready  = w_load_ready;
  assign bus.o_busy        = (r_state == RUN) || (r_state == DRAIN);
  assign bus.o_done        = (r_state == DONE);
  assign bus.o_oper        = r_oper;
  assign bus.o_argA        = r_argA;
  assign bus.o_argB        = r_argB;
  assign bus.o_issue_valid = r_issue_valid;
  assign bus.o_res_valid   = r_res_valid;
  assign bus.o_res_idx     = r_res_idx;
  assign bus.o_res_data    = r_res_data;
  assign bus.o_res_status  = r_res_status;
  assign bus.o_status_acc  = r_status_acc;
endmodule

// File: tb/tb_exe_op_issuer.sv
// Scoreboard bench for exe_op_issuer: two instances (LAT=1 and LAT=3) share
// the same directed stimulus; a behavioural exe unit answers each one with
// matching latency, and a monitor pops hand-computed expected results.
module tb_exe_op_issuer;
  logic       clk = 1'b0;
  logic       rsn;
  logic       ldValid;
  logic       start;
  logic [1:0] ldOper;
  logic [3:0] ldA;
  logic [3:0] ldB;

  int checks   = 0;
  int failures = 0;
  int tbCount  = 0;

  logic [8:0] q0 [$];
  logic [8:0] q1 [$];

  always #5 clk = ~clk;

  exe_op_issuer_if #(.m(4), .n(2), .DEPTH(8)) if1 ();
  exe_op_issuer_if #(.m(4), .n(2), .DEPTH(8)) if3 ();

  exe_op_issuer #(.m(4), .n(2), .DEPTH(8), .LAT(1)) dut1 (.i_clk(clk), .i_rsn(rsn), .bus(if1.slave));
  exe_op_issuer #(.m(4), .n(2), .DEPTH(8), .LAT(3)) dut3 (.i_clk(clk), .i_rsn(rsn), .bus(if3.slave));

  assign if1.i_load_valid = ldValid;
  assign if1.i_load_oper  = ldOper;
  assign if1.i_load_argA  = ldA;
  assign if1.i_load_argB  = ldB;
  assign if1.i_start      = start;
  assign if3.i_load_valid = ldValid;
  assign if3.i_load_oper  = ldOper;
  assign if3.i_load_argA  = ldA;
  assign if3.i_load_argB  = ldB;
  assign if3.i_start      = start;

  // Behavioural exe unit: 0 add, 1 sub, 2 xor, 3 negate A; status is B[1:0]
  function automatic logic [3:0] exeF(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return 4'd0 - a;
    endcase
  endfunction

  logic [1:0] d1Op, d2Op;
  logic [3:0] d1A, d2A, d1B, d2B;

  // The LAT=3 unit answers from a two-stage delayed copy of its operands
  always @(posedge clk) begin
    d1Op <= if3.o_oper;
    d1A  <= if3.o_argA;
    d1B  <= if3.o_argB;
    d2Op <= d1Op;
    d2A  <= d1A;
    d2B  <= d1B;
  end

  assign if1.i_result = exeF(if1.o_oper, if1.o_argA, if1.o_argB);
  assign if1.i_status = if1.o_argB[1:0];
  assign if3.i_result = exeF(d2Op, d2A, d2B);
  assign if3.i_status = d2B[1:0];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic popCheck(input int d, input logic [8:0] act);
    logic [8:0] exp;
    checks++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      failures++;
      $display("[TB] FAIL res_unexpected_%0d actual=idx%0d data=%h st=%b required=none", d, act[8:6], act[5:2], act[1:0]);
    end else begin
      exp = (d == 0) ? q0.pop_front() : q1.pop_front();
      if (act != exp) begin
        failures++;
        $display("[TB] FAIL res_%0d actual=idx%0d data=%h st=%b required=idx%0d data=%h st=%b",
                 d, act[8:6], act[5:2], act[1:0], exp[8:6], exp[5:2], exp[1:0]);
      end
    end
  endtask

  // Monitor: every presented result is matched against the scoreboard in order
  always @(negedge clk) begin
    if (!rsn) begin
      if (if1.o_res_valid) popCheck(0, {if1.o_res_idx, if1.o_res_data, if1.o_res_status});
      if (if3.o_res_valid) popCheck(1, {if3.o_res_idx, if3.o_res_data, if3.o_res_status});
    end
  end

  // Load one command (and optionally start in the same cycle); accepted loads enter the scoreboard
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] r, input logic [1:0] st, input bit withStart);
    logic [2:0] idx;
    if (tbCount < 8) begin
      idx = tbCount[2:0];
      q0.push_back({idx, r, st});
      q1.push_back({idx, r, st});
      tbCount++;
    end
    ldValid = 1'b1;
    ldOper  = op;
    ldA     = a;
    ldB     = b;
    start   = withStart;
    @(negedge clk);
    ldValid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic startOnly();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_L1"}, int'({if1.o_busy, if1.o_done, if1.o_issue_valid, if1.o_oper, if1.o_argA,
                 if1.o_argB, if1.o_res_valid, if1.o_res_idx, if1.o_res_data, if1.o_res_status,
                 if1.o_status_acc, if1.o_load_ready}), 1);
    checkOutput({name, "_L3"}, int'({if3.o_busy, if3.o_done, if3.o_issue_valid, if3.o_oper, if3.o_argA,
                 if3.o_argB, if3.o_res_valid, if3.o_res_idx, if3.o_res_data, if3.o_res_status,
                 if3.o_status_acc, if3.o_load_ready}), 1);
  endtask

  // Observe a run from the first cycle after the start edge; optionally keep hammering load/start while it runs
  task automatic watchRun(input int expC, input bit junk, input string name);
    int  lat[2], firstIss[2], firstRes[2], lastRes[2], issN[2], resN[2], busyN[2], doneN[2], doneCyc[2];
    bit  iv[2], rv[2], bz[2], dn[2];
    lat[0] = 1;
    lat[1] = 3;
    for (int d = 0; d < 2; d++) begin
      firstIss[d] = -1; firstRes[d] = -1; lastRes[d] = -1; doneCyc[d] = -1;
      issN[d] = 0; resN[d] = 0; busyN[d] = 0; doneN[d] = 0;
    end
    for (int cyc = 1; cyc <= 60; cyc++) begin
      iv[0] = if1.o_issue_valid; rv[0] = if1.o_res_valid; bz[0] = if1.o_busy; dn[0] = if1.o_done;
      iv[1] = if3.o_issue_valid; rv[1] = if3.o_res_valid; bz[1] = if3.o_busy; dn[1] = if3.o_done;
      for (int d = 0; d < 2; d++) begin
        if (iv[d]) begin issN[d]++; if (firstIss[d] < 0) firstIss[d] = cyc; end
        if (rv[d]) begin resN[d]++; lastRes[d] = cyc; if (firstRes[d] < 0) firstRes[d] = cyc; end
        if (bz[d]) busyN[d]++;
        if (dn[d]) begin doneN[d]++; doneCyc[d] = cyc; end
      end
      ldValid = junk && (cyc <= expC);
      start   = junk && (cyc <= expC);
      ldOper  = 2'd1;
      ldA     = 4'h9;
      ldB     = 4'h3;
      if (doneCyc[0] > 0 && doneCyc[1] > 0 && cyc >= doneCyc[1] + 2 && cyc >= doneCyc[0] + 2) break;
      @(negedge clk);
    end
    ldValid = 1'b0;
    start   = 1'b0;
    for (int d = 0; d < 2; d++) begin
      string s;
      s = $sformatf("%s_L%0d", name, lat[d]);
      checkOutput({s, "_issue_cycles"}, issN[d], expC);
      checkOutput({s, "_res_cycles"}, resN[d], expC);
      checkOutput({s, "_done_pulses"}, doneN[d], 1);
      checkOutput({s, "_done_cycle"}, doneCyc[d], (expC > 0) ? expC + 1 + lat[d] : 1);
      checkOutput({s, "_busy_cycles"}, busyN[d], (expC > 0) ? expC + lat[d] : 0);
      if (expC > 0) begin
        checkOutput({s, "_first_issue"}, firstIss[d], 2);
        checkOutput({s, "_first_res"}, firstRes[d], 2 + lat[d]);
        checkOutput({s, "_last_res"}, lastRes[d], expC + 1 + lat[d]);
      end
    end
    checkOutput({name, "_sb_left_L1"}, q0.size(), 0);
    checkOutput({name, "_sb_left_L3"}, q1.size(), 0);
    tbCount = 0;
  endtask

  // Overall time bound so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  // Directed test sequence
  initial begin
    int issued;
    int resSeen;
    rsn     = 1'b1;
    ldValid = 1'b0;
    start   = 1'b0;
    ldOper  = '0;
    ldA     = '0;
    ldB     = '0;
    repeat (3) @(negedge clk);
    checkResetState("reset_state");
    rsn = 1'b0;

    // Negate A with LAT 1 and 3: 5 -> B, -3 -> 3
    applyStimulus(2'd3, 4'h5, 4'h0, 4'hB, 2'b00, 1'b0);
    applyStimulus(2'd3, 4'hD, 4'h0, 4'h3, 2'b00, 1'b0);
    startOnly();
    watchRun(2, 1'b0, "neg2");

    // Fill all eight entries, then a ninth load that must be refused
    applyStimulus(2'd0, 4'h3, 4'h4, 4'h7, 2'b00, 1'b0);
    applyStimulus(2'd0, 4'h7, 4'h4, 4'hB, 2'b00, 1'b0);
    applyStimulus(2'd1, 4'h2, 4'h5, 4'hD, 2'b01, 1'b0);
    applyStimulus(2'd1, 4'h8, 4'h1, 4'h7, 2'b01, 1'b0);
    applyStimulus(2'd2, 4'hA, 4'h6, 4'hC, 2'b10, 1'b0);
    applyStimulus(2'd2, 4'hF, 4'hF, 4'h0, 2'b11, 1'b0);
    applyStimulus(2'd3, 4'h8, 4'h0, 4'h8, 2'b00, 1'b0);
    applyStimulus(2'd3, 4'h1, 4'h2, 4'hF, 2'b10, 1'b0);
    checkOutput("full_ready_L1", int'(if1.o_load_ready), 0);
    checkOutput("full_ready_L3", int'(if3.o_load_ready), 0);
    applyStimulus(2'd0, 4'h1, 4'h1, 4'h2, 2'b01, 1'b0);
    startOnly();
    watchRun(8, 1'b0, "full8");

    // Statuses 01 on idx0 and 10 on idx2 accumulate to 11
    applyStimulus(2'd0, 4'h1, 4'h1, 4'h2, 2'b01, 1'b0);
    applyStimulus(2'd0, 4'h2, 4'h0, 4'h2, 2'b00, 1'b0);
    applyStimulus(2'd0, 4'h3, 4'h2, 4'h5, 2'b10, 1'b0);
    applyStimulus(2'd0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    startOnly();
    watchRun(4, 1'b0, "stat4");
    checkOutput("acc_after_run_L1", int'(if1.o_status_acc), 3);
    checkOutput("acc_after_run_L3", int'(if3.o_status_acc), 3);

    // Start on an empty buffer: immediate done, accumulator cleared
    startOnly();
    watchRun(0, 1'b0, "empty");
    checkOutput("acc_cleared_L1", int'(if1.o_status_acc), 0);
    checkOutput("acc_cleared_L3", int'(if3.o_status_acc), 0);

    // Load together with start makes two commands; loads during the run are refused
    applyStimulus(2'd1, 4'h6, 4'h2, 4'h4, 2'b10, 1'b0);
    applyStimulus(2'd2, 4'h5, 4'h3, 4'h6, 2'b11, 1'b1);
    watchRun(2, 1'b1, "loadstart");
    startOnly();
    watchRun(0, 1'b0, "after_loadstart");

    // Reset in the middle of a five-command run, after three issues
    applyStimulus(2'd0, 4'h1, 4'h0, 4'h1, 2'b00, 1'b0);
    applyStimulus(2'd0, 4'h2, 4'h0, 4'h2, 2'b00, 1'b0);
    applyStimulus(2'd0, 4'h3, 4'h0, 4'h3, 2'b00, 1'b0);
    applyStimulus(2'd0, 4'h4, 4'h0, 4'h4, 2'b00, 1'b0);
    applyStimulus(2'd0, 4'h5, 4'h0, 4'h5, 2'b00, 1'b0);
    startOnly();
    issued = 0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      if (if1.o_issue_valid) issued++;
      if (cyc < 4) @(negedge clk);
    end
    checkOutput("midrun_issued", issued, 3);
    rsn = 1'b1;
    @(posedge clk);
    #1;
    q0.delete();
    q1.delete();
    tbCount = 0;
    @(negedge clk);
    checkResetState("midrun_reset");
    rsn = 1'b0;
    resSeen = 0;
    repeat (8) begin
      @(negedge clk);
      if (if1.o_res_valid || if3.o_res_valid || if1.o_issue_valid || if3.o_issue_valid) resSeen++;
    end
    checkOutput("after_reset_quiet", resSeen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
